pipeline_stall_controller: RTL

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller_pkg.sv | 22 ++
 rtl/pipeline_stall_controller_if.sv | 40 ++++
 rtl/pipeline_stall_controller_watchdog.sv | 28 ++
 rtl/pipeline_stall_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared encodings and defaults for the pipeline stall controller.
// Optional stall-cycle counter is enabled with `define STALL_COUNTER_EN.
package pipeline_stall_controller_pkg;

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] DIV_WAIT   = 2'd2;
  localparam logic [1:0] MEM_WAIT   = 2'd3;

  localparam int DIV_MAX_CYCLES_DEF = 34;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_if_id;
    logic bubble_id_ex;
    logic bubble_ex_mem;
  } ctrl_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard requests in, pipeline hold/flush controls out.
// Shared by the controller (slave) and the pipeline (master).
interface pipeline_stall_controller_if #(
  parameter int CNT_WIDTH = 32
);

  logic LOAD_USE_BUBBLE;
  logic DIV_START;
  logic DIV_DONE;
  logic BRANCH_TAKEN;
  logic MEM_BUSY;

  logic STALL_IF;
  logic STALL_ID;
  logic STALL_EX;
  logic STALL_MEM;
  logic FLUSH_IF_ID;
  logic BUBBLE_ID_EX;
  logic BUBBLE_EX_MEM;
  logic [1:0] CTRL_STATE;
  logic DIV_TIMEOUT_ERR;
  logic [CNT_WIDTH-1:0] STALL_COUNT;

  modport master (
    output LOAD_USE_BUBBLE, DIV_START, DIV_DONE,
    output BRANCH_TAKEN, MEM_BUSY,
    input  STALL_IF, STALL_ID, STALL_EX, STALL_MEM,
    input  FLUSH_IF_ID, BUBBLE_ID_EX, BUBBLE_EX_MEM,
    input  CTRL_STATE, DIV_TIMEOUT_ERR, STALL_COUNT
  );

  modport slave (
    input  LOAD_USE_BUBBLE, DIV_START, DIV_DONE,
    input  BRANCH_TAKEN, MEM_BUSY,
    output STALL_IF, STALL_ID, STALL_EX, STALL_MEM,
    output FLUSH_IF_ID, BUBBLE_ID_EX, BUBBLE_EX_MEM,
    output CTRL_STATE, DIV_TIMEOUT_ERR, STALL_COUNT
  );

endinterface

// File: rtl/pipeline_stall_controller_watchdog.sv
// Divider watchdog: counts enabled cycles, flags when the
// count about to be registered reaches the limit.
module stall_watchdog #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W:0]   nxt;

  assign nxt = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
  assign expired_o = nxt >= {1'b0, limit_i};

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= nxt[W-1:0];
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard FSM: load-use, divider wait and memory wait.
// Define STALL_COUNTER_EN to build the STALL_IF cycle counter.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int DIV_MAX_CYCLES = DIV_MAX_CYCLES_DEF
) (
  input logic CLK,
  input logic RESET,
  pipeline_stall_controller_if.slave bus
);

  localparam int WDW = $clog2(DIV_MAX_CYCLES + 1);

  logic [1:0] state_q, state_d;
  logic [1:0] ret_q, ret_d;
  logic [1:0] eff;
  logic       err_q, err_d;
  logic       wd_clr, wd_en, wd_exp;
  logic       br, ds, lu;
  ctrl_t      ctl;

  assign br = bus.BRANCH_TAKEN;
  assign ds = bus.DIV_START;
  assign lu = bus.LOAD_USE_BUBBLE;

  stall_watchdog #(.W(WDW)) u_wd (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .clear_i   (wd_clr),
    .enable_i  (wd_en),
    .limit_i   (WDW'(DIV_MAX_CYCLES)),
    .expired_o (wd_exp)
  );

  // Leaving MEM_WAIT behaves as the saved state in the same cycle
  assign eff = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d = eff;
    ret_d   = ret_q;
    err_d   = err_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    ctl     = '0;
    if (bus.MEM_BUSY) begin
      ctl.stall_if  = 1'b1;
      ctl.stall_id  = 1'b1;
      ctl.stall_ex  = 1'b1;
      ctl.stall_mem = 1'b1;
      state_d       = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else begin
      unique case (eff)
        RUN: begin
          unique case (1'b1)
            br: begin
              ctl.flush_if_id  = 1'b1;
              ctl.bubble_id_ex = 1'b1;
            end
            ds && !br: begin
              ctl.stall_if      = 1'b1;
              ctl.stall_id      = 1'b1;
              ctl.stall_ex      = 1'b1;
              ctl.bubble_ex_mem = 1'b1;
              wd_clr            = 1'b1;
              state_d           = DIV_WAIT;
            end
            lu && !br && !ds: begin
              ctl.stall_if     = 1'b1;
              ctl.bubble_id_ex = 1'b1;
              state_d          = LOAD_STALL;
            end
            default: ;
          endcase
        end
        LOAD_STALL: state_d = RUN;
        DIV_WAIT: begin
          if (bus.DIV_DONE) begin
            state_d = RUN;
          end else begin
            ctl.stall_if      = 1'b1;
            ctl.stall_id      = 1'b1;
            ctl.stall_ex      = 1'b1;
            ctl.bubble_ex_mem = 1'b1;
            wd_en             = 1'b1;
            if (wd_exp) begin
              err_d   = 1'b1;
              state_d = RUN;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
    if (RESET) ctl = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      ret_q   <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
    end
  end

  assign bus.STALL_IF        = ctl.stall_if;
  assign bus.STALL_ID        = ctl.stall_id;
  assign bus.STALL_EX        = ctl.stall_ex;
  assign bus.STALL_MEM       = ctl.stall_mem;
  assign bus.FLUSH_IF_ID     = ctl.flush_if_id;
  assign bus.BUBBLE_ID_EX    = ctl.bubble_id_ex;
  assign bus.BUBBLE_EX_MEM   = ctl.bubble_ex_mem;
  assign bus.CTRL_STATE      = state_q;
  assign bus.DIV_TIMEOUT_ERR = err_q;

`ifdef STALL_COUNTER_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (ctl.stall_if) begin
      cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.STALL_COUNT = cnt_q;
`else
  assign bus.STALL_COUNT = {CNT_WIDTH{1'b0}};
`endif

endmodule
